proc_trace_capture: RTL



---
 rtl/proc_trace_capture.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/proc_trace_capture.sv
// proc_trace_capture
//
// Trace unit that sits beside the pipelined core and records architectural
// side effects (register-file writebacks and data-memory stores) into an
// on-chip circular buffer. It covers one bounded run of CYCLE_LIMIT cycles.
// When the run ends, the buffer is read out oldest-first through a
// one-cycle-latency port.
//
// Optional feature: define TRACE_PC_TRIGGER_EN to add the trig_pc port.
// A fetch PC equal to trig_pc then ends the run early.
//
// Ports:
//   clock, reset           system clock, synchronous active-high reset
//   start                  pulse, arms a run from IDLE
//   clear                  pulse, DONE -> IDLE and empties the buffer
//   ctrl_writeEnable       regfile write strobe
//   ctrl_writeReg          regfile destination register
//   data_writeReg          regfile write data
//   wren                   dmem write strobe
//   address_dmem, data     dmem store address / data
//   pc                     current fetch PC
//   trig_pc                PC trigger value (TRACE_PC_TRIGGER_EN only)
//   rd_en, rd_idx          readout request, index 0 = oldest entry
//   rd_valid, rd_data      readout response {kind, stamp, addr, data}
//   done                   high while in DONE
//   count                  number of valid entries
//   dropped                entries lost to overwrite/discard, saturating
module proc_trace_capture #(
    parameter int  DEPTH       = 16,
    parameter int  CYCLE_LIMIT = 50,
    parameter int  CYC_W       = 16,
    parameter int  WRAP        = 1,
    localparam int AW          = $clog2(DEPTH),
    localparam int EW          = 45 + CYC_W
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          clear,
    input  logic          ctrl_writeEnable,
    input  logic [4:0]    ctrl_writeReg,
    input  logic [31:0]   data_writeReg,
    input  logic          wren,
    input  logic [11:0]   address_dmem,
    input  logic [31:0]   data,
    input  logic [31:0]   pc,
`ifdef TRACE_PC_TRIGGER_EN
    input  logic [31:0]   trig_pc,
`endif
    input  logic          rd_en,
    input  logic [AW-1:0] rd_idx,
    output logic          rd_valid,
    output logic [EW-1:0] rd_data,
    output logic          done,
    output logic [AW:0]   count,
    output logic [15:0]   dropped
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [CYC_W-1:0] cycle_cnt;
    logic [AW-1:0]    wr_ptr;
    logic [EW-1:0]    mem [DEPTH];

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {15'd0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    logic          in_run;
    logic          rf_ev;
    logic          dm_ev;
    logic          trig_hit;
    logic          last_cycle;
    logic [1:0]    n_ev;
    logic [1:0]    n_store;
    logic [1:0]    n_lost;
    logic [AW+1:0] cnt_sum;
    logic [AW+1:0] free;
    logic [AW:0]   count_nx;
    logic [EW-1:0] rf_entry;
    logic [EW-1:0] dm_entry;
    logic [EW-1:0] slot0;
    logic [AW-1:0] rd_ptr;
    logic          rd_hit;

    assign in_run     = (state == S_RUN);
    // Writes to r0 have no architectural effect, so they are not traced.
    assign rf_ev      = in_run && ctrl_writeEnable && (ctrl_writeReg != 5'd0);
    assign dm_ev      = in_run && wren;
    assign n_ev       = {1'b0, rf_ev} + {1'b0, dm_ev};
    assign last_cycle = (cycle_cnt == CYC_W'(CYCLE_LIMIT - 1));

    assign rf_entry = {1'b0, cycle_cnt, 7'd0, ctrl_writeReg, data_writeReg};
    assign dm_entry = {1'b1, cycle_cnt, address_dmem, data};
    // The regfile entry always takes the first slot when both events fire.
    assign slot0    = rf_ev ? rf_entry : dm_entry;

`ifdef TRACE_PC_TRIGGER_EN
    assign trig_hit = (pc == trig_pc);
`else
    logic unused_pc;
    assign unused_pc = ^pc;
    assign trig_hit  = 1'b0;
`endif

    // Decide how many of this cycle's events land in the buffer and how many are lost.
    always_comb begin
        cnt_sum  = {1'b0, count} + {{AW{1'b0}}, n_ev};
        free     = (AW+2)'(DEPTH) - {1'b0, count};
        n_store  = n_ev;
        n_lost   = 2'd0;
        count_nx = cnt_sum[AW:0];
        if (WRAP != 0) begin
            // Everything is written; whatever spills past DEPTH displaced the oldest.
            if (cnt_sum > (AW+2)'(DEPTH)) begin
                n_lost   = 2'(cnt_sum - (AW+2)'(DEPTH));
                count_nx = (AW+1)'(DEPTH);
            end
        end else if ({{AW{1'b0}}, n_ev} > free) begin
            // Only as many as fit are kept, regfile first, so a partial fit drops the store.
            n_store  = free[1:0];
            n_lost   = n_ev - free[1:0];
            count_nx = (AW+1)'(DEPTH);
        end
    end

    // Oldest entry sits count slots behind the write pointer.
    assign rd_ptr = wr_ptr - count[AW-1:0] + rd_idx;
    assign rd_hit = ({1'b0, rd_idx} < count);

    // Buffer storage: contents survive reset and clear.
    always_ff @(posedge clock) begin
        if (n_store != 2'd0) begin
            mem[wr_ptr] <= slot0;
        end
        if (n_store == 2'd2) begin
            mem[wr_ptr + AW'(1)] <= dm_entry;
        end
    end

    // Control state, counters and the registered readout port.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            cycle_cnt <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            dropped   <= '0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
        end else begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            case (state)
                S_IDLE: begin
                    cycle_cnt <= '0;
                    wr_ptr    <= '0;
                    count     <= '0;
                    dropped   <= '0;
                    if (start) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    wr_ptr    <= wr_ptr + AW'(n_store);
                    count     <= count_nx;
                    dropped   <= sat_add16(dropped, n_lost);
                    cycle_cnt <= cycle_cnt + CYC_W'(1);
                    if (last_cycle || trig_hit) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (rd_en) begin
                        rd_valid <= 1'b1;
                        rd_data  <= rd_hit ? mem[rd_ptr] : '0;
                    end
                    // clear has priority; start is simply not looked at here.
                    if (clear) begin
                        state     <= S_IDLE;
                        cycle_cnt <= '0;
                        wr_ptr    <= '0;
                        count     <= '0;
                        dropped   <= '0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign done = (state == S_DONE);

endmodule
